matrix_operand_loader: RTL and testbench
========================================

// Module: matrix_operand_loader
// PURPOSE
//  Upstream feeder for square_matrix_mult. Deserialises a word stream into operand matrices A then B.
//  Receives one width-bit FP32 element per handshake beat, row-major: A first, then B.
//  Once both matrices are full, presents them as flat vectors and holds out_ready until the consumer acks.
//  Optional column-major storage of B gives the multiplier linear column access.
// PARAMETERS
//  size         2    matrix dimension N
//  size_square  4    N*N elements per matrix; must equal size*size (elaboration-time check)
//  width        32   element width (IEEE-754 single)
//  TRANSPOSE_B  0    1: element B[r][c] is stored at flat index c*size+r; 0: stored at r*size+c
// PORTS
//  in_clk        in   1                   clock, rising edge
//  in_reset      in   1                   reset in_reset, asynchronous, active-low
//  in_valid      in   1                   in_data holds a valid element
//  in_data       in   width               element value
//  out_accept    out  1                   loader can take a beat; beat transfers when in_valid & out_accept
//  in_abort      in   1                   sync: discard partial load, restart at A[0]
//  in_ack        in   1                   consumer has captured matrices; honoured only while out_ready=1
//  out_matrix_a  out  width*size_square   A; element k at bits [k*width +: width]
//  out_matrix_b  out  width*size_square   B, same packing; order per TRANSPOSE_B
//  out_ready     out  1                   both matrices complete and stable
//  out_count     out  $clog2(2*size_square+1)  beats accepted in current load (0..2*size_square)
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=S_LOAD_A, counters 0, out_accept=1, out_ready=0,
//   out_count=0, out_matrix_a/b all zeros.
//  States: S_LOAD_A -> S_LOAD_B -> S_PRESENT -> S_LOAD_A.
//   S_LOAD_A: out_accept=1. Each beat writes A[idx], idx++. Beat with idx==size_square-1 -> S_LOAD_B, idx=0.
//   S_LOAD_B: out_accept=1. Each beat writes B[map(idx)], idx++. Last beat -> S_PRESENT.
//   S_PRESENT: out_accept=0, out_ready=1. Matrices frozen. in_ack -> S_LOAD_A, idx=0, out_count=0.
//  map(idx): TRANSPOSE_B=0 -> idx. TRANSPOSE_B=1 -> (idx%size)*size + idx/size.
//   Implement with separate row/col counters; no divider.
//  out_accept and out_ready are decoded from registered state only (no combinational path from in_valid).
//  Latency: last B beat accepted on edge k -> out_ready=1 and out_accept=0 from edge k onward. No bubble.
//  in_ack with out_ready=1 on edge k -> out_accept=1 after edge k. First new beat can be taken on edge k+1.
//  out_count increments per accepted beat. Holds 2*size_square in S_PRESENT.
//  Matrix registers are not cleared on ack or abort; they are only overwritten by new beats.
//  Boundaries:
//   - in_valid during S_PRESENT: ignored (no write, no count).
//   - in_ack outside S_PRESENT: ignored.
//   - in_abort in any state: next state S_LOAD_A, idx/out_count=0, out_ready=0. Abort wins over a same-cycle beat
//     (beat dropped) and over a same-cycle in_ack.
//   - in_reset asserted mid-load or mid-present: immediate return to reset values; partial data lost.
//   - in_valid gaps: no timeout; loader waits indefinitely.
// STRUCTURE
//  Shared package matrix_pkg: state encodings (S_LOAD_A/S_LOAD_B/S_PRESENT), FP width localparam,
//   element-slice helper function shared with square_matrix_mult.
//  No sub-module. Single FSM, row/col counters and write-enable decode in one file.
// TESTING
//  T1 size=2, TRANSPOSE_B=0: stream 1.0..8.0 back-to-back -> A flat = {1,2,3,4}, B flat = {5,6,7,8};
//     out_ready rises on the 8th beat edge; out_count=8.
//  T2 TRANSPOSE_B=1, same stream -> B flat order = {5,7,6,8}; A unchanged.
//  T3 hold in_valid=1 with data 9.0 during S_PRESENT for 5 cycles -> no change to A/B/out_count;
//     in_ack -> out_accept=1 next cycle; next beat writes A[0]=9.0.
//  T4 in_abort after 3 A beats -> out_count=0, state S_LOAD_A. A full 8-beat reload then gives out_ready.
//     A beat coincident with the abort is not written.
//  T5 in_reset low mid-S_LOAD_B (beat 6) -> all outputs return to reset values asynchronously; reload works.
//  T6 size=3 with random in_valid gaps and in_ack delays -> scoreboard matches row-major A and B
//     for 20 consecutive loads.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: definitions shared by matrix_operand_loader and square_matrix_mult.
//   state_e   : loader FSM encodings
//   FP_W      : IEEE-754 single-precision element width
//   elem_lsb  : low bit of element k in a flat vector of w-bit elements
package matrix_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: deserialises a row-major element stream into operand
// matrices A then B, then presents both until the consumer acks.
// Ports:
//   in_clk, in_reset      clock (rising edge), async active-low reset
//   in_valid, in_data     element beat; transfers when in_valid & out_accept
//   out_accept            loader can take a beat (registered-state decode)
//   in_abort              sync: drop partial load, restart at A[0]
//   in_ack                consumer captured matrices; only honoured in S_PRESENT
//   out_matrix_a/_b       flat matrices, element k at [k*width +: width]
//   out_ready             both matrices complete and stable
//   out_count             beats accepted in the current load
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int size        = 2,
  parameter int size_square = 4,
  parameter int width       = FP_W,
  parameter int TRANSPOSE_B = 0
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic                          in_valid,
  input  logic [width-1:0]              in_data,
  output logic                          out_accept,
  input  logic                          in_abort,
  input  logic                          in_ack,
  output logic [width*size_square-1:0]  out_matrix_a,
  output logic [width*size_square-1:0]  out_matrix_b,
  output logic                          out_ready,
  output logic [$clog2(2*size_square+1)-1:0] out_count
);

  localparam int IW = (size_square > 1) ? $clog2(size_square) : 1;
  localparam int RW = (size > 1) ? $clog2(size) : 1;
  localparam int CW = $clog2(2*size_square+1);
  localparam logic [IW-1:0] IDX_LAST = IW'(size_square-1);
  localparam logic [RW-1:0] RC_LAST  = RW'(size-1);
  localparam logic [IW-1:0] SZ       = IW'(size);

  if (size_square != size*size) begin : g_bad_size
    $error("matrix_operand_loader: size_square must equal size*size");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [size_square-1:0][width-1:0] a_q, b_q;
  logic [size_square-1:0]            we_a, we_b;

  logic          beat;
  logic [IW-1:0] b_addr;

  // Handshake outputs come purely from registered state.
  assign out_accept = (state_q != S_PRESENT);
  assign out_ready  = (state_q == S_PRESENT);
  assign out_count  = cnt_q;

  // Abort drops a coincident beat.
  assign beat = in_valid & out_accept & ~in_abort;

  // Stream arrives row-major; row/col counters give the transposed address
  // col*size+row with a constant multiply instead of a divide/modulo.
  assign b_addr = (TRANSPOSE_B != 0) ? (IW'(col_q) * SZ + IW'(row_q)) : idx_q;

  always_comb begin
    we_a = '0;
    we_b = '0;
    for (int k = 0; k < size_square; k++) begin
      we_a[k] = beat && (state_q == S_LOAD_A) && (idx_q  == IW'(k));
      we_b[k] = beat && (state_q == S_LOAD_B) && (b_addr == IW'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    if (in_abort) begin
      state_d = S_LOAD_A;
      idx_d   = '0;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD_A, S_LOAD_B: begin
          if (beat) begin
            cnt_d = cnt_q + CW'(1);
            if (idx_q == IDX_LAST) begin
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_PRESENT;
              idx_d   = '0;
              row_d   = '0;
              col_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
              if (col_q == RC_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
              end else begin
                col_d = col_q + RW'(1);
              end
            end
          end
        end
        S_PRESENT: begin
          if (in_ack) begin
            state_d = S_LOAD_A;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_LOAD_A;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= S_LOAD_A;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Matrix storage is only ever overwritten by beats, never cleared by ack/abort.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int k = 0; k < size_square; k++) begin
        if (we_a[k]) a_q[k] <= in_data;
        if (we_b[k]) b_q[k] <= in_data;
      end
    end
  end

  for (genvar k = 0; k < size_square; k++) begin : g_out
    assign out_matrix_a[elem_lsb(k, width) +: width] = a_q[k];
    assign out_matrix_b[elem_lsb(k, width) +: width] = b_q[k];
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  logic        in_reset;
  logic        in_valid, in_abort, in_ack;
  logic [31:0] in_data;

  logic         acc_n, rdy_n, acc_t, rdy_t;
  logic [127:0] ma_n, mb_n, ma_t, mb_t;
  logic [3:0]   cnt_n, cnt_t;

  logic         in_valid3, in_abort3, in_ack3;
  logic [31:0]  in_data3;
  logic         acc3, rdy3;
  logic [287:0] ma3, mb3;
  logic [4:0]   cnt3;

  matrix_operand_loader #(.size(2), .size_square(4), .width(32), .TRANSPOSE_B(0)) u_n (
    .in_clk(in_clk), .in_reset(in_reset), .in_valid(in_valid), .in_data(in_data),
    .out_accept(acc_n), .in_abort(in_abort), .in_ack(in_ack),
    .out_matrix_a(ma_n), .out_matrix_b(mb_n), .out_ready(rdy_n), .out_count(cnt_n));

  matrix_operand_loader #(.size(2), .size_square(4), .width(32), .TRANSPOSE_B(1)) u_t (
    .in_clk(in_clk), .in_reset(in_reset), .in_valid(in_valid), .in_data(in_data),
    .out_accept(acc_t), .in_abort(in_abort), .in_ack(in_ack),
    .out_matrix_a(ma_t), .out_matrix_b(mb_t), .out_ready(rdy_t), .out_count(cnt_t));

  matrix_operand_loader #(.size(3), .size_square(9), .width(32), .TRANSPOSE_B(0)) u_3 (
    .in_clk(in_clk), .in_reset(in_reset), .in_valid(in_valid3), .in_data(in_data3),
    .out_accept(acc3), .in_abort(in_abort3), .in_ack(in_ack3),
    .out_matrix_a(ma3), .out_matrix_b(mb3), .out_ready(rdy3), .out_count(cnt3));

  int n_cmp = 0;
  int n_err = 0;

  // IEEE-754 single encodings of 0.0 .. 9.0
  logic [31:0] fp [0:9];

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic cyc();
    @(posedge in_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
  endtask

  logic [31:0] w [0:17];
  logic [8:0][31:0] ea3, eb3;

  initial begin
    fp[0] = 32'h00000000; fp[1] = 32'h3F800000; fp[2] = 32'h40000000;
    fp[3] = 32'h40400000; fp[4] = 32'h40800000; fp[5] = 32'h40A00000;
    fp[6] = 32'h40C00000; fp[7] = 32'h40E00000; fp[8] = 32'h41000000;
    fp[9] = 32'h41100000;

    in_reset = 1'b0; in_valid = 1'b0; in_abort = 1'b0; in_ack = 1'b0; in_data = '0;
    in_valid3 = 1'b0; in_abort3 = 1'b0; in_ack3 = 1'b0; in_data3 = '0;
    #12;
    // reset state
    chk("rst_cnt", 288'(cnt_n), 288'(0));
    chk("rst_acc", 288'(acc_n), 288'(1));
    chk("rst_rdy", 288'(rdy_n), 288'(0));
    chk("rst_a",   288'(ma_n),  288'(0));
    chk("rst_b",   288'(mb_t),  288'(0));
    #11 in_reset = 1'b1;
    cyc();

    // T1/T2: 1.0..8.0 back-to-back
    for (int i = 1; i <= 7; i++) send(fp[i]);
    chk("t1_rdy_7", 288'(rdy_n), 288'(0));
    chk("t1_cnt_7", 288'(cnt_n), 288'(7));
    send(fp[8]);
    in_data = fp[9];
    chk("t1_rdy",  288'(rdy_n), 288'(1));
    chk("t1_acc",  288'(acc_n), 288'(0));
    chk("t1_cnt",  288'(cnt_n), 288'(8));
    chk("t1_a",    288'(ma_n),  288'(pack4(fp[1], fp[2], fp[3], fp[4])));
    chk("t1_b",    288'(mb_n),  288'(pack4(fp[5], fp[6], fp[7], fp[8])));
    chk("t2_a",    288'(ma_t),  288'(pack4(fp[1], fp[2], fp[3], fp[4])));
    chk("t2_b",    288'(mb_t),  288'(pack4(fp[5], fp[7], fp[6], fp[8])));
    chk("t2_rdy",  288'(rdy_t), 288'(1));

    // T3: valid held with 9.0 while presenting
    repeat (5) cyc();
    chk("t3_cnt",  288'(cnt_n), 288'(8));
    chk("t3_a",    288'(ma_n),  288'(pack4(fp[1], fp[2], fp[3], fp[4])));
    chk("t3_b",    288'(mb_t),  288'(pack4(fp[5], fp[7], fp[6], fp[8])));
    chk("t3_rdy",  288'(rdy_n), 288'(1));
    in_ack = 1'b1;
    cyc();
    in_ack = 1'b0;
    chk("t3_ack_acc", 288'(acc_n), 288'(1));
    chk("t3_ack_rdy", 288'(rdy_n), 288'(0));
    chk("t3_ack_cnt", 288'(cnt_n), 288'(0));
    chk("t3_ack_a",   288'(ma_n),  288'(pack4(fp[1], fp[2], fp[3], fp[4])));
    cyc();
    chk("t3_a0",  288'(ma_n[31:0]), 288'(fp[9]));
    chk("t3_cnt1", 288'(cnt_n), 288'(1));

    // T4: abort after 3 A beats with coincident beat
    send(32'h000000A1);
    send(32'h000000A2);
    chk("t4_cnt3", 288'(cnt_n), 288'(3));
    in_abort = 1'b1;
    in_data  = 32'hDEADBEEF;
    cyc();
    in_abort = 1'b0;
    in_valid = 1'b0;
    chk("t4_cnt",  288'(cnt_n), 288'(0));
    chk("t4_acc",  288'(acc_n), 288'(1));
    chk("t4_rdy",  288'(rdy_n), 288'(0));
    chk("t4_a",    288'(ma_n),  288'(pack4(fp[9], 32'hA1, 32'hA2, fp[4])));
    in_ack = 1'b1;
    cyc();
    in_ack = 1'b0;
    chk("t4_ack_ign", 288'(cnt_n), 288'(0));
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
    in_valid = 1'b0;
    chk("t4_rdy2", 288'(rdy_n), 288'(1));
    chk("t4_cnt8", 288'(cnt_n), 288'(8));
    chk("t4_a2",   288'(ma_n),  288'(pack4(32'h100, 32'h101, 32'h102, 32'h103)));
    chk("t4_b2",   288'(mb_n),  288'(pack4(32'h104, 32'h105, 32'h106, 32'h107)));
    chk("t4_bt2",  288'(mb_t),  288'(pack4(32'h104, 32'h106, 32'h105, 32'h107)));

    // T5: async reset mid S_LOAD_B
    in_ack = 1'b1;
    cyc();
    in_ack = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h200 + 32'(i));
    in_valid = 1'b0;
    chk("t5_pre_cnt", 288'(cnt_n), 288'(5));
    #2 in_reset = 1'b0;
    #1;
    chk("t5_cnt", 288'(cnt_n), 288'(0));
    chk("t5_acc", 288'(acc_n), 288'(1));
    chk("t5_rdy", 288'(rdy_n), 288'(0));
    chk("t5_a",   288'(ma_n),  288'(0));
    chk("t5_b",   288'(mb_n),  288'(0));
    chk("t5_bt",  288'(mb_t),  288'(0));
    #1 in_reset = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) send(32'h300 + 32'(i));
    in_valid = 1'b0;
    chk("t5_rdy2", 288'(rdy_n), 288'(1));
    chk("t5_a2",   288'(ma_n),  288'(pack4(32'h300, 32'h301, 32'h302, 32'h303)));
    chk("t5_bt2",  288'(mb_t),  288'(pack4(32'h304, 32'h306, 32'h305, 32'h307)));

    // T6: size=3, random gaps and ack delays, 20 loads
    for (int ld = 0; ld < 20; ld++) begin
      for (int i = 0; i < 18; i++) begin
        w[i] = $urandom;
        repeat ($urandom_range(0, 2)) begin
          in_valid3 = 1'b0;
          in_data3  = $urandom;
          cyc();
        end
        in_valid3 = 1'b1;
        in_data3  = w[i];
        cyc();
      end
      in_valid3 = 1'b0;
      for (int k = 0; k < 9; k++) begin
        ea3[k] = w[k];
        eb3[k] = w[9+k];
      end
      chk("t6_rdy", 288'(rdy3), 288'(1));
      chk("t6_cnt", 288'(cnt3), 288'(18));
      repeat ($urandom_range(0, 3)) cyc();
      chk("t6_a", ma3, 288'(ea3));
      chk("t6_b", mb3, 288'(eb3));
      in_ack3 = 1'b1;
      cyc();
      in_ack3 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
